map_mem_arbiter: RTL and testbench

Arbitrates the single-port 14x14 game map RAM between two requesters: the VGA renderer, which reads one cell per pixel strobe, and the game engine, which posts cell writes through a small write queue. It also sequences a full-map clear sweep on request. It sits between Game, the graphics block and the map RAM in the snake top level, and all logic runs on the 100 MHz board clock.

---
 rtl/map_pkg.sv | 27 ++
 rtl/map_wq_fifo.sv | 60 ++++++
 rtl/map_mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_map_mem_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/map_pkg.sv
// Shared map definitions for the snake game: map geometry, cell colours,
// arbiter state encoding and the write-queue entry layout.
package map_pkg;

  localparam int MAP_WIDTH   = 14;
  localparam int MAP_HEIGHT  = 14;
  localparam int MAP_DEPTH   = MAP_WIDTH * MAP_HEIGHT;
  localparam int MAP_A_WIDTH = 8;
  localparam int MAP_D_WIDTH = 2;

  typedef logic [MAP_A_WIDTH-1:0] map_addr_t;
  typedef logic [MAP_D_WIDTH-1:0] cell_t;

  localparam cell_t CELL_LIME  = 2'b00;
  localparam cell_t CELL_GLASS = 2'b01;
  localparam cell_t CELL_WHITE = 2'b10;
  localparam cell_t CELL_BLACK = 2'b11;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  typedef struct packed {
    map_addr_t addr;
    cell_t     data;
  } wq_entry_t;

endpackage

// File: rtl/map_wq_fifo.sv
// Small synchronous FIFO holding pending game-engine cell writes.
// Push is refused when full, pop is ignored when empty.
module map_wq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rptr];

  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop  & ~o_empty;

  // NOTE: storage has no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together at the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/map_mem_arbiter.sv
// Single-port map RAM arbiter: clear sweep > renderer read > queued game write.
// All RAM controls are registered; reads return three cycles after acceptance.
module map_mem_arbiter
  import map_pkg::*;
#(
  parameter int    WQ_DEPTH  = 4,
  parameter cell_t CLEAR_VAL = CELL_LIME
) (
  input  logic                   CLK,
  input  logic                   RST_BTN,
  input  logic                   pix_stb,
  input  logic                   rd_req,
  input  logic [MAP_A_WIDTH-1:0] rd_addr,
  output logic [MAP_D_WIDTH-1:0] rd_data,
  output logic                   rd_valid,
  input  logic                   wr_req,
  input  logic [MAP_A_WIDTH-1:0] wr_addr,
  input  logic [MAP_D_WIDTH-1:0] wr_data,
  output logic                   wr_ready,
  input  logic                   clr_start,
  output logic                   clr_busy,
  output logic                   err_drop,
  output logic [MAP_A_WIDTH-1:0] mem_addr,
  output logic                   mem_we,
  output logic [MAP_D_WIDTH-1:0] mem_wdata,
  input  logic [MAP_D_WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(WQ_DEPTH) + 1;

  logic [0:0]             r_state;
  logic [MAP_A_WIDTH-1:0] r_cnt;
  logic [MAP_A_WIDTH-1:0] r_mem_addr;
  logic                   r_mem_we;
  logic [MAP_D_WIDTH-1:0] r_mem_wdata;
  logic                   r_rd_p1;
  logic                   r_rd_p2;
  logic                   r_clr_p1;
  logic                   r_clr_p2;
  logic                   r_rd_valid;
  logic [MAP_D_WIDTH-1:0] r_rd_data;
  logic                   r_err;

  wq_entry_t              w_new;
  wq_entry_t              w_head;
  logic                   w_full;
  logic                   w_empty;
  logic [CW-1:0]          w_count;
  logic                   w_rd_acc;
  logic                   w_clr_ctx;
  logic                   w_sweep_last;
  logic                   w_pop;

  assign w_new        = '{addr: wr_addr, data: wr_data};
  assign w_rd_acc     = rd_req & pix_stb;
  assign w_sweep_last = (r_state == ST_CLEAR) && (r_cnt == MAP_A_WIDTH'(MAP_DEPTH - 1));
  // A read accepted while the sweep owns the next RAM slot is answered with CLEAR_VAL.
  assign w_clr_ctx    = (r_state == ST_CLEAR) || clr_start;
  assign w_pop        = (r_state == ST_IDLE) && !clr_start && !w_rd_acc && !w_empty;

  map_wq_fifo #(
    .DEPTH (WQ_DEPTH),
    .WIDTH ($bits(wq_entry_t))
  ) u_wq (
    .clk     (CLK),
    .rst_n   (RST_BTN),
    .i_push  (wr_req),
    .i_din   (w_new),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (clr_start) begin
            r_state     <= ST_CLEAR;
            r_cnt       <= '0;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= '0;
            r_mem_wdata <= CLEAR_VAL;
          end else if (w_rd_acc) begin
            r_mem_addr  <= rd_addr;
          end else if (w_pop) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= w_head.addr;
            r_mem_wdata <= w_head.data;
          end
        end
        ST_CLEAR: begin
          if (w_sweep_last) begin
            r_state     <= ST_IDLE;
          end else begin
            r_cnt       <= r_cnt + MAP_A_WIDTH'(1);
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_cnt + MAP_A_WIDTH'(1);
            r_mem_wdata <= CLEAR_VAL;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Read pipeline: address out at N+1, RAM data at N+2, result at N+3.
  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      r_rd_p1    <= 1'b0;
      r_rd_p2    <= 1'b0;
      r_clr_p1   <= 1'b0;
      r_clr_p2   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_p1    <= w_rd_acc;
      r_clr_p1   <= w_rd_acc & w_clr_ctx;
      r_rd_p2    <= r_rd_p1;
      r_clr_p2   <= r_clr_p1;
      r_rd_valid <= r_rd_p2;
      if (r_rd_p2) r_rd_data <= r_clr_p2 ? CLEAR_VAL : mem_rdata;
    end
  end

  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN)             r_err <= 1'b0;
    else if (wr_req & w_full) r_err <= 1'b1;
  end

  assign wr_ready  = (w_count != CW'(WQ_DEPTH));
  assign clr_busy  = (r_state == ST_CLEAR);
  assign err_drop  = r_err;
  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;

endmodule

// File: tb/tb_map_mem_arbiter.sv
// Self-checking bench for map_mem_arbiter: directed scenarios plus random
// traffic against a transaction-level model with its own shadow of the map RAM.
module tb_map_mem_arbiter;

  logic       CLK = 1'b0;
  logic       RST_BTN;
  logic       pix_stb, rd_req, wr_req, clr_start;
  logic [7:0] rd_addr, wr_addr, mem_addr;
  logic [1:0] wr_data, rd_data, mem_wdata;
  logic [1:0] mem_rdata = 2'b00;
  logic       rd_valid, wr_ready, clr_busy, err_drop, mem_we;

  map_mem_arbiter dut (
    .CLK(CLK), .RST_BTN(RST_BTN), .pix_stb(pix_stb),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .clr_start(clr_start), .clr_busy(clr_busy), .err_drop(err_drop),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  // Environment: synchronous single-port RAM with one-cycle read latency.
  logic [1:0] ram [256];
  always @(posedge CLK) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  bit stb_hold = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: pending writes, pending read results, sweep progress, RAM shadow.
  typedef struct { logic [7:0] a; logic [1:0] d; } wr_t;
  typedef struct { int due; logic [1:0] v; } rd_t;
  wr_t        m_wq [$];
  rd_t        m_rd [$];
  logic [1:0] ref_ram [256];
  bit         m_busy;
  int         m_saddr;
  logic       e_we, e_rd, e_valid, e_ready, e_busy, e_err;
  logic [7:0] e_addr;
  logic [1:0] e_wdata, e_rdata;

  task automatic model_reset();
    m_wq.delete(); m_rd.delete();
    m_busy = 0; m_saddr = 0;
    e_we = 0; e_rd = 0; e_valid = 0; e_ready = 1; e_busy = 0; e_err = 0;
    e_addr = '0; e_wdata = '0; e_rdata = '0;
  endtask

  task automatic model_step(input logic stb, input logic rq, input logic [7:0] ra,
                            input logic wq, input logic [7:0] wa, input logic [1:0] wd,
                            input logic cs);
    int size0;
    logic acc, ctx;
    wr_t h;
    // The op of the cycle now ending lands in RAM before anything later reads it.
    if (e_we) ref_ram[e_addr] = e_wdata;
    acc   = rq & stb;
    ctx   = m_busy | cs;
    size0 = m_wq.size();
    if (acc) m_rd.push_back('{due: cyc + 3, v: ctx ? 2'b00 : ref_ram[ra]});
    e_we = 0; e_rd = 0;
    if (m_busy) begin
      if (m_saddr < 195) begin
        m_saddr++;
        e_we = 1; e_addr = 8'(m_saddr); e_wdata = 2'b00;
      end else m_busy = 0;
    end else if (cs) begin
      m_busy = 1; m_saddr = 0;
      e_we = 1; e_addr = 8'd0; e_wdata = 2'b00;
    end else if (acc) begin
      e_rd = 1; e_addr = ra;
    end else if (size0 > 0) begin
      h = m_wq.pop_front();
      e_we = 1; e_addr = h.a; e_wdata = h.d;
    end
    if (wq && size0 >= 4) e_err = 1;
    if (wq && size0 < 4)  m_wq.push_back('{a: wa, d: wd});
    e_ready = (m_wq.size() < 4);
    e_busy  = m_busy;
    if (m_rd.size() > 0 && m_rd[0].due == cyc + 1) begin
      e_valid = 1; e_rdata = m_rd[0].v; void'(m_rd.pop_front());
    end else e_valid = 0;
  endtask

  task automatic check_outputs();
    check("mem_we", mem_we, e_we);
    if (e_we) begin
      check("mem_addr_wr", mem_addr, e_addr);
      check("mem_wdata", mem_wdata, e_wdata);
    end
    if (e_rd) check("mem_addr_rd", mem_addr, e_addr);
    check("rd_valid", rd_valid, e_valid);
    check("rd_data", rd_data, e_rdata);
    check("wr_ready", wr_ready, e_ready);
    check("clr_busy", clr_busy, e_busy);
    check("err_drop", err_drop, e_err);
  endtask

  // One clock cycle: check current outputs, drive inputs, advance model, clock.
  task automatic step(input logic rq, input logic [7:0] ra, input logic wq,
                      input logic [7:0] wa, input logic [1:0] wd, input logic cs);
    logic stb;
    check_outputs();
    stb = stb_hold || (cyc % 4 == 0);
    pix_stb = stb; rd_req = rq; rd_addr = ra;
    wr_req = wq; wr_addr = wa; wr_data = wd; clr_start = cs;
    model_step(stb, rq, ra, wq, wa, wd, cs);
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'd0, 0, 8'd0, 2'd0, 0);
  endtask

  task automatic align();
    while (cyc % 4 != 0) idle(1);
  endtask

  task automatic do_reset();
    #1 RST_BTN = 1'b0;
    pix_stb = 0; rd_req = 0; rd_addr = 0; wr_req = 0; wr_addr = 0; wr_data = 0; clr_start = 0;
    #1;
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_data", rd_data, 2'b00);
    check("rst_wr_ready", wr_ready, 1'b1);
    check("rst_clr_busy", clr_busy, 1'b0);
    check("rst_err_drop", err_drop, 1'b0);
    check("rst_mem_addr", mem_addr, 8'd0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_wdata", mem_wdata, 2'b00);
    model_reset();
    @(negedge CLK); cyc++;
    @(negedge CLK); cyc++;
    RST_BTN = 1'b1;
  endtask

  initial begin
    logic [7:0] ra, wa;
    logic [1:0] wd;
    logic       rq, wq, cs;
    int         busy_cnt, guard;

    for (int i = 0; i < 256; i++) begin
      wd = 2'($urandom_range(0, 3));
      ram[i] = wd; ref_ram[i] = wd;
    end
    ram[5] = 2'b10; ref_ram[5] = 2'b10;
    ram[7] = 2'b01; ref_ram[7] = 2'b01;
    RST_BTN = 1'b1;
    model_reset();
    @(negedge CLK);
    do_reset();

    // 1: single read of address 5
    align();
    step(1, 8'd5, 0, 8'd0, 2'd0, 0);
    idle(2);
    check("t1_valid", rd_valid, 1'b1);
    check("t1_data", rd_data, 2'b10);
    idle(3);

    // 2: four queued writes with no reads
    for (int i = 0; i < 4; i++) step(0, 8'd0, 1, 8'(10 + i), 2'b01, 0);
    idle(6);

    // 3: strobe held high, reads every cycle, five writes back-to-back
    stb_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1, 8'($urandom_range(0, 195)), 1, 8'(20 + i), 2'(i), 0);
      if (i == 3) check("t3_ready_low", wr_ready, 1'b0);
    end
    check("t3_err", err_drop, 1'b1);
    for (int i = 0; i < 4; i++) step(1, 8'($urandom_range(0, 195)), 0, 8'd0, 2'd0, 0);
    stb_hold = 1'b0;
    for (int i = 0; i < 16; i++) step(1, 8'($urandom_range(0, 195)), 0, 8'd0, 2'd0, 0);
    idle(4);

    // 4 and 5: clear sweep with reads, a second clr_start and a write to 7
    align();
    step(0, 8'd0, 0, 8'd0, 2'd0, 1);
    busy_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (clr_busy) busy_cnt++;
      step(1, 8'($urandom_range(0, 195)), (i == 50), 8'd7, 2'b11, (i == 100));
    end
    check("t4_busy_cycles", busy_cnt, 196);
    idle(8);
    align();
    step(1, 8'd7, 0, 8'd0, 2'd0, 0);
    idle(2);
    check("t5_valid", rd_valid, 1'b1);
    check("t5_rd7", rd_data, 2'b11);
    idle(3);

    // 6: reset in the middle of a sweep
    align();
    step(0, 8'd0, 0, 8'd0, 2'd0, 1);
    guard = 0;
    while (!(e_busy && e_we && e_addr == 8'd50) && guard < 300) begin
      idle(1);
      guard++;
    end
    check("t6_reached_addr50", (guard < 300), 1'b1);
    do_reset();
    idle(20);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      rq = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(196, 255)) : 8'($urandom_range(0, 195));
      wq = ($urandom_range(0, 2) == 0);
      wa = 8'($urandom_range(0, 195));
      wd = 2'($urandom_range(0, 3));
      cs = ($urandom_range(0, 599) == 0);
      step(rq, ra, wq, wa, wd, cs);
    end
    idle(10);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
